four_step_seq: RTL

//  Parametrised four-step commutation sequencer for the SVM matrix-converter switch drive.

---
 rtl/four_step_seq_if.sv | 17 +
 rtl/four_step_seq.sv | 113 +++++++++++
 2 files changed

// File: rtl/four_step_seq_if.sv
// Switch-vector command/drive bundle for the four-step commutation sequencer.
// The controller side is the master; the sequencer is the slave.
interface four_step_seq_if #(
  parameter int N_PH = 3
);
  localparam int W = 2 * N_PH;

  logic [W-1:0] vnew;
  logic         dir;
  logic         mode;
  logic [W-1:0] vout;
  logic         busy;
  logic         done;

  modport master (output vnew, dir, mode, input  vout, busy, done);
  modport slave  (input  vnew, dir, mode, output vout, busy, done);
endinterface

// File: rtl/four_step_seq.sv
// Four-step commutation sequencer for bidirectional switch pairs (even bit = forward,
// odd bit = reverse). Walks three current-sign-dependent patterns between vectors.
module four_step_seq #(
  parameter int              N_PH      = 3,
  parameter int              DWELL     = 2,
  parameter logic [2*N_PH-1:0] RESET_VEC = 6'b000011
) (
  input  logic           clk,
  input  logic           rst,
  four_step_seq_if.slave bus
);
  localparam int W  = 2 * N_PH;
  localparam int CW = $clog2(DWELL + 1);

  localparam logic [W-1:0]  EVEN_MASK = {N_PH{2'b01}};
  localparam logic [W-1:0]  ODD_MASK  = {N_PH{2'b10}};
  localparam logic [CW-1:0] CNT_LOAD  = CW'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S1   = 2'd1,
    S2   = 2'd2,
    S3   = 2'd3
  } state_t;

  state_t         st;
  logic [W-1:0]   vcur;
  logic [W-1:0]   tgt;
  logic [W-1:0]   m;
  logic [W-1:0]   vout_q;
  logic [CW-1:0]  cnt;
  logic           busy_q;
  logic           done_q;
  logic [W-1:0]   dir_mask;

  // Positive current flows through the forward devices, so those are the ones kept on.
  assign dir_mask = bus.dir ? EVEN_MASK : ODD_MASK;

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values; mixing in blocking writes would create ordering-dependent logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= IDLE;
      vcur   <= RESET_VEC;
      vout_q <= RESET_VEC;
      tgt    <= RESET_VEC;
      m      <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (st)
        IDLE: begin
          vout_q <= vcur;
          busy_q <= 1'b0;
          if (bus.vnew != vcur) begin
            if (bus.mode) begin
              vcur   <= bus.vnew;
              vout_q <= bus.vnew;
              done_q <= 1'b1;
            end else begin
              tgt    <= bus.vnew;
              m      <= dir_mask;
              vout_q <= vcur & dir_mask;
              cnt    <= CNT_LOAD;
              busy_q <= 1'b1;
              st     <= S1;
            end
          end
        end
        S1: begin
          if (cnt == '0) begin
            vout_q <= (vcur & m) | (tgt & m);
            cnt    <= CNT_LOAD;
            st     <= S2;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S2: begin
          if (cnt == '0) begin
            vout_q <= tgt & m;
            cnt    <= CNT_LOAD;
            st     <= S3;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S3: begin
          if (cnt == '0) begin
            vout_q <= tgt;
            vcur   <= tgt;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            st     <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          st     <= IDLE;
          vout_q <= vcur;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.vout = vout_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule
